// File: rtl/idu_pipe_if.sv
// idu_pipe_if: fetch-side and execute-side handshake bundle for idu_pipe
interface idu_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_op;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_itype;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_func3, out_func7, out_rd,
           out_rs1, out_rs2, out_itype, out_imm, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_func3, out_func7, out_rd,
           out_rs1, out_rs2, out_itype, out_imm, out_illegal
  );
endinterface

// File: rtl/idu_pipe.sv
// idu_pipe: registered RISC-V decode stage with a 2-entry skid buffer
module idu_pipe #(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  idu_pipe_if.slave   io
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      op;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      itype;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } ent_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam bit RV64 = (RV64_OPS != 0) && (XLEN == 64);
  state_t state_q, state_d;
  ent_t   m_q, m_d, k_q, k_d, dec;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire;
  logic [6:0] op;
  logic [2:0] itype;
  logic [31:0] ins;
  always_comb begin
    ins = io.in_instr;
    op = ins[6:0];
    itype = (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || (RV64 && op == 7'h1b)) ? 3'd0 :
            (op == 7'h37 || op == 7'h17) ? 3'd1 :
            (op == 7'h23) ? 3'd2 :
            (op == 7'h63) ? 3'd3 :
            (op == 7'h6f) ? 3'd4 :
            (op == 7'h33 || (RV64 && op == 7'h3b)) ? 3'd5 : 3'd7;
    dec.pc      = io.in_pc;
    dec.op      = op;
    dec.func3   = ins[14:12];
    dec.func7   = ins[31:25];
    dec.rd      = ins[11:7];
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.itype   = itype;
    dec.illegal = itype == 3'd7;
    dec.imm = itype == 3'd0 ? XLEN'($signed(ins[31:20])) :
              itype == 3'd1 ? XLEN'($signed({ins[31:12], 12'b0})) :
              itype == 3'd2 ? XLEN'($signed({ins[31:25], ins[11:7]})) :
              itype == 3'd3 ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
              itype == 3'd4 ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
              '0;
  end
  assign in_fire  = io.in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && io.out_ready;
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    k_d = k_q;
    if (flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (in_fire) begin state_d = ONE; m_d = dec; end
        ONE:
          if (in_fire && out_fire) m_d = dec;
          else if (in_fire) begin state_d = TWO; k_d = dec; end
          else if (out_fire) state_d = EMPTY;
        TWO: if (out_fire) begin state_d = ONE; m_d = k_q; end
        default: state_d = EMPTY;
      endcase
    in_ready_d = state_d != TWO;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      m_q <= '0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      m_q <= m_d;
      k_q <= k_d;
    end
  end
  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = state_q != EMPTY;
  assign io.out_pc      = m_q.pc;
  assign io.out_op      = m_q.op;
  assign io.out_func3   = m_q.func3;
  assign io.out_func7   = m_q.func7;
  assign io.out_rd      = m_q.rd;
  assign io.out_rs1     = m_q.rs1;
  assign io.out_rs2     = m_q.rs2;
  assign io.out_itype   = m_q.itype;
  assign io.out_imm     = m_q.imm;
  assign io.out_illegal = m_q.illegal;
endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
Registered instruction-decode stage, parametrised successor to the combinational decoder. It accepts one fetched instruction per cycle over a valid/ready handshake. Immediate format is derived internally from the opcode, so no external ExtOP is needed. Decoded fields go into a 2-entry skid buffer between IFU and EXU, giving full throughput under backpressure; flush and illegal-instruction detection are included.

Parameters:
XLEN, 32, datapath width; 32 or 64; immediates sign-extended to XLEN.
RV64_OPS, 0, when 1 (XLEN=64 only), opcodes 0011011/0111011 (OP-IMM-32/OP-32) are legal.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard all buffered entries this cycle
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept (registered)
in_instr  input  32  raw instruction
in_pc  input  XLEN  instruction PC
out_valid  output  1  decoded entry available
out_ready  input  1  downstream accepts
out_pc  output  XLEN  PC of entry
out_op  output  7  instr[6:0]
out_func3  output  3  instr[14:12]
out_func7  output  7  instr[31:25]
out_rd  output  5  instr[11:7]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_itype  output  3  0=I 1=U 2=S 3=B 4=J 5=R 7=illegal
out_imm  output  XLEN  sign-extended immediate
out_illegal  output  1  entry is illegal instruction

Behaviour:
- Decode is combinational on in_instr, then captured; no latency beyond the register: accepted at edge N, visible on out_* after edge N.
- Opcode->itype: 0010011/0000011/1100111/1110011 -> I; 0110111/0010111 -> U; 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110011 -> R (imm=0). 0011011 -> I and 0111011 -> R only if RV64_OPS=1.
- Immediates: I {s,instr[31:20]}; U {s,instr[31:12],12'b0}; S {s,instr[31:25],instr[11:7]}; B {s,instr[7],instr[30:25],instr[11:8],0}; J {s,instr[19:12],instr[20],instr[30:21],0}; s = replicated instr[31] to XLEN.
- Illegal: instr[1:0]!=2'b11 or unlisted opcode -> itype=7, imm=0, out_illegal=1; other fields still pass raw bits. Illegal entries flow through the handshake normally.
- Storage: main register M (drives out_*), skid register K. States EMPTY (M,K invalid), ONE (M valid), TWO (M,K valid).
- Transfers: in_fire = in_valid&in_ready; out_fire = out_valid&out_ready.
  - EMPTY: in_fire -> ONE (load M).
  - ONE: in_fire&out_fire -> ONE (M<=new); in_fire&!out_fire -> TWO (K<=new); !in_fire&out_fire -> EMPTY.
  - TWO: out_fire -> ONE (M<=K); in_ready=0 so no input accepted.
- in_ready = (state!=TWO), a flop output, no combinational path from out_ready.
- out_valid = (state!=EMPTY). out_* stable while out_valid&!out_ready.
- flush: next state EMPTY regardless of in_valid/out_ready; in_fire in a flush cycle is dropped. in_ready=1 cycle after flush.
- rst: state EMPTY, out_valid=0, in_ready=1 from first post-reset cycle; all out_* data = 0. Reset mid-operation drops all entries.
- rst has priority over flush; flush over handshake.
- No $display or other simulation-only output in RTL.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, rd=1, itype=0, imm=0xFFFFFFFF, illegal=0.
- lui x1,0x12345 (0x123450B7), then sw x2,8(x1) (0x0020A423) back-to-back -> imm 0x12345000 itype 1, then imm 0x8 itype 2, one per cycle.
- out_ready=0, push 3 instrs -> first two accepted, in_ready=0 after second, third held; raise out_ready -> outputs in order, no loss/duplication.
- TWO state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed input not output.
- 0x00000000 and opcode 0x7F -> out_illegal=1, itype=7, imm=0.
- XLEN=64: jal x0,-4 (0xFFDFF06F) -> itype 4, imm=0xFFFFFFFFFFFFFFFC; 0x0000009B (addiw) illegal when RV64_OPS=0, legal I when 1.
